// File: rtl/memory_arbiter_if.sv
// Requester and RAM signals of the instruction/data memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding datapath/RAM.
interface memory_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic [DATA_W-1:0] iload;
    logic              ihit;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic [DATA_W-1:0] dload;
    logic              dhit;
    logic              halt;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ramready;
    logic              busy;
    logic              timeout_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramready,
        output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore,
               busy, timeout_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramready,
        input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore,
               busy, timeout_err
    );
endinterface

// File: rtl/memory_arbiter.sv
// Single-ported RAM arbiter: data port has strict priority over instruction fetch,
// one grant at a time, registered outputs, and a sticky watchdog timeout.
module memory_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input logic               CLK,
    input logic               RST,
    memory_arbiter_if.slave   bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, DACC, IACC, RESP, ERR} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ramren_q, ramren_d;
    logic               ramwen_q, ramwen_d;
    logic [ADDR_W-1:0]  ramaddr_q, ramaddr_d;
    logic [DATA_W-1:0]  ramstore_q, ramstore_d;
    logic [DATA_W-1:0]  iload_q, iload_d;
    logic [DATA_W-1:0]  dload_q, dload_d;
    logic               ihit_q, ihit_d;
    logic               dhit_q, dhit_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic               last_cycle;

    assign last_cycle = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ramren_d   = 1'b0;
        ramwen_d   = 1'b0;
        ramaddr_d  = ramaddr_q;
        ramstore_d = ramstore_q;
        iload_d    = iload_q;
        dload_d    = dload_q;
        ihit_d     = 1'b0;
        dhit_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dREN || bus.dWEN) begin
                    state_d    = DACC;
                    cnt_d      = '0;
                    ramwen_d   = bus.dWEN;
                    ramren_d   = !bus.dWEN;
                    ramaddr_d  = bus.daddr;
                    ramstore_d = bus.dstore;
                end else if (bus.iREN && !bus.halt) begin
                    state_d    = IACC;
                    cnt_d      = '0;
                    ramren_d   = 1'b1;
                    ramaddr_d  = bus.iaddr;
                end
            end
            DACC, IACC: begin
                // ready in the final allowed cycle still completes the access
                if (bus.ramready) begin
                    state_d = RESP;
                    if (state_q == DACC) begin
                        dhit_d = 1'b1;
                        if (ramren_q) dload_d = bus.ramload;
                    end else begin
                        ihit_d  = 1'b1;
                        iload_d = bus.ramload;
                    end
                end else if (last_cycle) begin
                    state_d = ERR;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    ramren_d = ramren_q;
                    ramwen_d = ramwen_q;
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = ERR;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        err_d  = err_q || (state_d == ERR);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ramren_q   <= 1'b0;
            ramwen_q   <= 1'b0;
            ramaddr_q  <= '0;
            ramstore_q <= '0;
            iload_q    <= '0;
            dload_q    <= '0;
            ihit_q     <= 1'b0;
            dhit_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ramren_q   <= ramren_d;
            ramwen_q   <= ramwen_d;
            ramaddr_q  <= ramaddr_d;
            ramstore_q <= ramstore_d;
            iload_q    <= iload_d;
            dload_q    <= dload_d;
            ihit_q     <= ihit_d;
            dhit_q     <= dhit_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign bus.ramREN      = ramren_q;
    assign bus.ramWEN      = ramwen_q;
    assign bus.ramaddr     = ramaddr_q;
    assign bus.ramstore    = ramstore_q;
    assign bus.iload       = iload_q;
    assign bus.dload       = dload_q;
    assign bus.ihit        = ihit_q;
    assign bus.dhit        = dhit_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = err_q;
endmodule
